// File: rtl/filter_out_serializer.sv
// filter_out_serializer
// Output end of the 3-parallel FIR datapath. Each 3-lane word from the filter
// goes into a small FIFO and leaves as one sample per cycle under a VOUT/RDY
// handshake. DOUT and VOUT are registers loaded from the next-state values, so
// no input reaches them through combinational logic.

module filter_out_serializer #(
    parameter int NB    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NB-1:0]            DIN0,
    input  logic [NB-1:0]            DIN1,
    input  logic [NB-1:0]            DIN2,
    input  logic                     VIN,
    output logic [NB-1:0]            DOUT,
    output logic                     VOUT,
    input  logic                     RDY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = 3 * NB;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);

    // Lane 0 is the oldest sample and sits in the top bits of a stored word.
    function automatic logic [NB-1:0] lane_sel(input logic [WW-1:0] word,
                                               input logic [1:0]    lane);
        logic [NB-1:0] sample;
        case (lane)
            2'd0:    sample = word[WW-1:2*NB];
            2'd1:    sample = word[2*NB-1:NB];
            2'd2:    sample = word[NB-1:0];
            default: sample = {NB{1'b0}};
        endcase
        return sample;
    endfunction

    // Registered state
    logic [WW-1:0]  mem_r [DEPTH];
    logic [AW-1:0]  rd_ptr_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [1:0]     lane_r;
    logic [LW-1:0]  level_r;
    logic           ovf_r;
    logic [NB-1:0]  dout_r;
    logic           vout_r;

    // Next-state signals
    logic [WW-1:0]  din_word_s;
    logic           xfer_s;
    logic           pop_s;
    logic           push_ok_s;
    logic           drop_s;
    logic [LW-1:0]  level_nxt_s;
    logic [AW-1:0]  rd_ptr_nxt_s;
    logic [AW-1:0]  wr_ptr_nxt_s;
    logic [1:0]     lane_nxt_s;
    logic [WW-1:0]  head_word_nxt_s;
    logic [NB-1:0]  dout_nxt_s;

    assign din_word_s = {DIN0, DIN1, DIN2};

    // Handshake, push acceptance and pointer/level/lane next-state
    always_comb begin
        xfer_s       = vout_r & RDY;
        pop_s        = xfer_s & (lane_r == 2'd2);
        // A full FIFO still accepts when the head word leaves on the same edge.
        push_ok_s    = VIN & ((level_r < LVL_DEPTH) | pop_s);
        drop_s       = VIN & ~push_ok_s;

        case ({push_ok_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (xfer_s) begin
            if (lane_r == 2'd2) begin
                lane_nxt_s = 2'd0;
            end else begin
                lane_nxt_s = lane_r + 2'd1;
            end
        end else begin
            lane_nxt_s = lane_r;
        end
    end

    // Head word and output sample as they will be after this edge; an incoming
    // word that becomes the only entry is not in memory yet, so bypass it.
    always_comb begin
        if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_word_nxt_s = din_word_s;
        end else begin
            head_word_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        if (level_nxt_s != LVL_ZERO) begin
            dout_nxt_s = lane_sel(head_word_nxt_s, lane_nxt_s);
        end else begin
            dout_nxt_s = {NB{1'b0}};
        end
    end

    // FIFO storage; cleared on reset so DOUT can never expose stale data
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WW{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din_word_s;
        end
    end

    // Pointers, lane counter, level, sticky overflow and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            lane_r   <= 2'd0;
            level_r  <= LVL_ZERO;
            ovf_r    <= 1'b0;
            dout_r   <= {NB{1'b0}};
            vout_r   <= 1'b0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            lane_r   <= lane_nxt_s;
            level_r  <= level_nxt_s;
            ovf_r    <= ovf_r | drop_s;
            dout_r   <= dout_nxt_s;
            vout_r   <= (level_nxt_s != LVL_ZERO);
        end
    end

    assign DOUT  = dout_r;
    assign VOUT  = vout_r;
    assign LEVEL = level_r;
    assign OVF   = ovf_r;

endmodule

// File: tb/tb_filter_out_serializer.sv
// Directed testbench for filter_out_serializer (NB=8, DEPTH=4).
// Hand-computed sequences plus a sample queue for the longer streams.

module tb_filter_out_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] DIN0;
    logic [7:0] DIN1;
    logic [7:0] DIN2;
    logic       VIN;
    logic [7:0] DOUT;
    logic       VOUT;
    logic       RDY;
    logic [2:0] LEVEL;
    logic       OVF;

    int n_chk;
    int n_pass;

    logic [7:0] exp_q[$];

    filter_out_serializer #(.NB(8), .DEPTH(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .DIN0  (DIN0),
        .DIN1  (DIN1),
        .DIN2  (DIN2),
        .VIN   (VIN),
        .DOUT  (DOUT),
        .VOUT  (VOUT),
        .RDY   (RDY),
        .LEVEL (LEVEL),
        .OVF   (OVF)
    );

    // 10 time-unit clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One cycle: drive inputs, compare outputs with the sample queue, update
    // the queue for the coming edge, then advance past the edge.
    task automatic cyc(input logic vin, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic acc, input logic rdy);
        VIN  = vin;
        DIN0 = a;
        DIN1 = b;
        DIN2 = c;
        RDY  = rdy;
        chk("vout", {31'd0, VOUT}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("dout", {24'd0, DOUT}, {24'd0, exp_q[0]});
            if (rdy) begin
                void'(exp_q.pop_front());
            end
        end else begin
            chk("dout_idle", {24'd0, DOUT}, 32'd0);
        end
        if (vin && acc) begin
            exp_q.push_back(a);
            exp_q.push_back(b);
            exp_q.push_back(c);
        end
        step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        VIN = 1'b0;
        RDY = 1'b0;
        step();
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
            guard++;
        end
        chk({tag, "_drain_bound"}, {31'd0, guard < 60}, 32'd1);
        chk({tag, "_vout_end"}, {31'd0, VOUT}, 32'd0);
        chk({tag, "_level_end"}, {29'd0, LEVEL}, 32'd0);
    endtask

    initial begin
        logic [7:0] m20;
        logic       rdy_seq [5];
        logic [7:0] bp_exp  [5];
        logic [7:0] kk;

        n_chk  = 0;
        n_pass = 0;
        m20    = 8'hEC;   // -20

        // 1: reset with VIN asserted
        RST  = 1'b1;
        VIN  = 1'b1;
        RDY  = 1'b1;
        DIN0 = 8'd55;
        DIN1 = 8'd66;
        DIN2 = 8'd77;
        step();
        step();
        chk("rst_vout", {31'd0, VOUT}, 32'd0);
        chk("rst_dout", {24'd0, DOUT}, 32'd0);
        chk("rst_level", {29'd0, LEVEL}, 32'd0);
        chk("rst_ovf", {31'd0, OVF}, 32'd0);
        RST = 1'b0;
        VIN = 1'b0;

        // 2: single word 10,-20,30
        DIN0 = 8'd10;
        DIN1 = m20;
        DIN2 = 8'd30;
        VIN  = 1'b1;
        RDY  = 1'b1;
        step();
        VIN = 1'b0;
        chk("sw_lane0", {24'd0, DOUT}, 32'd10);
        chk("sw_vout0", {31'd0, VOUT}, 32'd1);
        chk("sw_level", {29'd0, LEVEL}, 32'd1);
        step();
        chk("sw_lane1", {24'd0, DOUT}, {24'd0, m20});
        step();
        chk("sw_lane2", {24'd0, DOUT}, 32'd30);
        chk("sw_vout2", {31'd0, VOUT}, 32'd1);
        step();
        chk("sw_vout_end", {31'd0, VOUT}, 32'd0);
        chk("sw_level_end", {29'd0, LEVEL}, 32'd0);
        chk("sw_dout_end", {24'd0, DOUT}, 32'd0);

        // 3: overflow, six back-to-back words with RDY=1
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            kk = 8'(k * 10);
            cyc(1'b1, kk + 8'd1, kk + 8'd2, kk + 8'd3, k <= 5, 1'b1);
            if (k == 5) begin
                chk("ovf_before", {31'd0, OVF}, 32'd0);
            end
        end
        VIN = 1'b0;
        chk("ovf_set", {31'd0, OVF}, 32'd1);
        chk("ovf_level", {29'd0, LEVEL}, 32'd4);
        drain("ovf");
        chk("ovf_sticky", {31'd0, OVF}, 32'd1);

        // 4: backpressure on word 1,2,3
        do_reset();
        cyc(1'b1, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
        VIN = 1'b0;
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bp_exp  = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
        for (int i = 0; i < 5; i++) begin
            RDY = rdy_seq[i];
            chk("bp_dout", {24'd0, DOUT}, {24'd0, bp_exp[i]});
            chk("bp_vout", {31'd0, VOUT}, 32'd1);
            step();
        end
        chk("bp_vout_end", {31'd0, VOUT}, 32'd0);
        chk("bp_level_end", {29'd0, LEVEL}, 32'd0);
        exp_q.delete();

        // 5: full FIFO, lane 2, push and pop on the same edge; then wrap
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            kk = 8'(k * 16);
            cyc(1'b1, kk + 8'd1, kk + 8'd2, kk + 8'd3, 1'b1, 1'b0);
        end
        chk("full_level", {29'd0, LEVEL}, 32'd4);
        cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        chk("full_lane2", {24'd0, DOUT}, 32'd19);
        cyc(1'b1, 8'd81, 8'd82, 8'd83, 1'b1, 1'b1);
        chk("full_sim_level", {29'd0, LEVEL}, 32'd4);
        chk("full_sim_ovf", {31'd0, OVF}, 32'd0);
        for (int k = 6; k <= 12; k++) begin
            kk = 8'(k * 16);
            cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
            cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
            cyc(1'b1, kk + 8'd1, kk + 8'd2, kk + 8'd3, 1'b1, 1'b1);
        end
        chk("wrap_level", {29'd0, LEVEL}, 32'd4);
        chk("wrap_ovf", {31'd0, OVF}, 32'd0);
        drain("wrap");

        // 6: reset in the middle of a word
        do_reset();
        cyc(1'b1, 8'd41, 8'd42, 8'd43, 1'b1, 1'b0);
        cyc(1'b1, 8'd51, 8'd52, 8'd53, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        chk("mid_lane1", {24'd0, DOUT}, 32'd42);
        RST = 1'b1;
        RDY = 1'b1;
        step();
        RST = 1'b0;
        exp_q.delete();
        chk("mid_vout", {31'd0, VOUT}, 32'd0);
        chk("mid_level", {29'd0, LEVEL}, 32'd0);
        chk("mid_ovf", {31'd0, OVF}, 32'd0);
        chk("mid_dout", {24'd0, DOUT}, 32'd0);
        cyc(1'b1, 8'd7, 8'd8, 8'd9, 1'b1, 1'b1);
        VIN = 1'b0;
        chk("mid_new_lane0", {24'd0, DOUT}, 32'd7);
        drain("mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
